memory_responder: RTL and testbench

Word-addressed RAM that serves the CPU's memory-data path. It accepts read and write requests addressed by the MAR, and takes write data from the MDR output. Each access runs through a small multi-cycle state machine with programmable wait states. Read data returns on `m_data_out`, which feeds the MDR's memory-side input, together with a one-cycle `mem_ready` completion strobe.

---
 rtl/memory_responder.sv | 146 ++++++++++++++
 tb/tb_memory_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
//
// Word-addressed RAM on the CPU memory-data path. A read or write request,
// addressed by the MAR, is latched in IDLE. The access then runs through
// WAIT (programmable wait states), ACCESS (one array access) and DONE (a
// one-cycle mem_ready strobe). Read data is registered onto m_data_out and
// holds there until the next read's ACCESS edge.
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN
//   defined   - the array has MEM_DEPTH words. A latched address >= MEM_DEPTH
//               drops a write, returns 0 for a read, and raises addr_err with
//               mem_ready.
//   undefined - the array has 2**ADDR_WIDTH words and addr_err is always 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (the array is not cleared)
//   read       in   read request, level, held until mem_ready
//   write      in   write request, level, held until mem_ready; wins over read
//   address    in   [ADDR_WIDTH-1:0] word address
//   mdr_data   in   [REG_SIZE-1:0] write data
//   m_data_out out  [REG_SIZE-1:0] read data, valid with mem_ready
//   mem_ready  out  one-cycle completion strobe
//   busy       out  high whenever the FSM is not in IDLE
//   addr_err   out  out-of-range flag, valid with mem_ready
// ---------------------------------------------------------------------------
module memory_responder #(
    parameter int REG_SIZE    = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2,    // 0..15
    parameter int MEM_DEPTH   = 400
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [REG_SIZE-1:0]   mdr_data,
    output logic [REG_SIZE-1:0]   m_data_out,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  addr_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    // The counter is loaded with WAIT_STATES-1: the edge that leaves WAIT
    // at count 0 is itself one of the wait cycles.
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef MEM_BOUNDS_CHECK_EN
    localparam int ARRAY_WORDS = MEM_DEPTH;
`else
    localparam int ARRAY_WORDS = 2 ** ADDR_WIDTH;
`endif

    logic [REG_SIZE-1:0]   mem [ARRAY_WORDS];

    state_t                state_reg;
    logic [3:0]            count_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [REG_SIZE-1:0]   wdata_reg;
    logic                  op_write_reg;
    logic [REG_SIZE-1:0]   data_out_reg;
    logic                  ready_reg;
    logic                  busy_reg;
    logic                  err_reg;
    logic                  in_range;

`ifdef MEM_BOUNDS_CHECK_EN
    assign in_range = (int'(addr_reg) < MEM_DEPTH);
`else
    // MEM_DEPTH only matters when bounds checking is built in.
    logic unused_depth;
    assign unused_depth = (MEM_DEPTH > 0);
    assign in_range     = 1'b1;
`endif

    // Array write port. It has no reset, so contents survive reset. A reset
    // that lands before the ACCESS edge returns the FSM to IDLE, so the write
    // is never committed.
    always_ff @(posedge clk) begin
        if (state_reg == S_ACCESS && op_write_reg && in_range) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            count_reg    <= 4'd0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            op_write_reg <= 1'b0;
            data_out_reg <= '0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (read || write) begin
                        addr_reg     <= address;
                        wdata_reg    <= mdr_data;
                        op_write_reg <= write;          // write wins when both are high
                        count_reg    <= WAIT_INIT;
                        busy_reg     <= 1'b1;
                        state_reg    <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count_reg == 4'd0) begin
                        state_reg <= S_ACCESS;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                S_ACCESS: begin
                    // Registered read; out-of-range reads return zero.
                    if (!op_write_reg) begin
                        data_out_reg <= in_range ? mem[addr_reg] : '0;
                    end
                    ready_reg <= 1'b1;
                    err_reg   <= !in_range;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    ready_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign m_data_out = data_out_reg;
    assign mem_ready  = ready_reg;
    assign busy       = busy_reg;
    assign addr_err   = err_reg;

endmodule

// File: tb/tb_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_memory_responder
//
// Directed bench for memory_responder. One instance uses the default two
// wait states. A second instance uses zero wait states and receives
// back-to-back reads. Inputs change and outputs are sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_memory_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        read, write;
    logic [8:0]  address;
    logic [31:0] mdr_data;
    logic [31:0] m_data_out;
    logic        mem_ready, busy, addr_err;

    logic        read0, write0;
    logic [8:0]  addr0;
    logic [31:0] wdata0;
    logic [31:0] q0;
    logic        ready0, busy0, err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_responder #(
        .REG_SIZE(32), .ADDR_WIDTH(9), .WAIT_STATES(WS), .MEM_DEPTH(400)
    ) dut (
        .clk(clk), .reset_n(reset_n), .read(read), .write(write),
        .address(address), .mdr_data(mdr_data), .m_data_out(m_data_out),
        .mem_ready(mem_ready), .busy(busy), .addr_err(addr_err)
    );

    memory_responder #(
        .REG_SIZE(32), .ADDR_WIDTH(9), .WAIT_STATES(0), .MEM_DEPTH(400)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .read(read0), .write(write0),
        .address(addr0), .mdr_data(wdata0), .m_data_out(q0),
        .mem_ready(ready0), .busy(busy0), .addr_err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the WS=2 instance. exp_q is the expected
    // m_data_out in the mem_ready cycle. For writes, exp_q is the value from
    // the previous read, which m_data_out must keep.
    task automatic txn(input logic rd, input logic wr, input logic [8:0] a,
                       input logic [31:0] d, input logic [31:0] exp_q,
                       input logic exp_err, input string tag);
        int  c;
        int  busy_cnt;
        bit  seen;
        @(negedge clk);
        read = rd; write = wr; address = a; mdr_data = d;
        c = 0; busy_cnt = 0; seen = 0;
        while (!seen && c < 10) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                address  = ~a;          // changes after latching must be ignored
                mdr_data = ~d;
            end
            if (busy) busy_cnt++;
            if (mem_ready) seen = 1;
        end
        check({tag, "_latency"}, 32'(c), 32'(WS + 2));
        check({tag, "_data"}, m_data_out, exp_q);
        check({tag, "_addr_err"}, 32'(addr_err), 32'(exp_err));
        read = 1'b0; write = 1'b0;
        @(negedge clk);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WS + 2));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_ready_after"}, 32'(mem_ready), 32'd0);
        check({tag, "_data_hold"}, m_data_out, exp_q);
    endtask

    initial begin
        int  c;
        bit  seen;
        int  pulses;

        reset_n = 1'b1;
        read = 1'b0; write = 1'b0; address = '0; mdr_data = '0;
        read0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;

        // Asynchronous reset, asserted mid-cycle.
        #3 reset_n = 1'b0;
        #1;
        check("rst_data", m_data_out, 32'd0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        txn(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0,        1'b0, "wr05");
        txn(1'b1, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF, 1'b0, "rd05");
        txn(1'b1, 1'b1, 9'h010, 32'h12345678, 32'hDEADBEEF, 1'b0, "rdwr10");
        txn(1'b1, 1'b0, 9'h010, 32'h0,        32'h12345678, 1'b0, "rd10");
        txn(1'b0, 1'b1, 9'h020, 32'h0BADF00D, 32'h12345678, 1'b0, "wr20");

        // Reset in the WAIT cycle: the write must not commit and no strobe may appear.
        @(negedge clk);
        write = 1'b1; address = 9'h020; mdr_data = 32'hAAAA5555;
        @(negedge clk);
        check("abort_busy_wait", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", m_data_out, 32'd0);
        write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("abort_no_ready", 32'(pulses), 32'd0);

        txn(1'b1, 1'b0, 9'h020, 32'h0, 32'h0BADF00D, 1'b0, "rd20_after_abort");
        txn(1'b1, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF, 1'b0, "rd05_after_reset");

`ifdef MEM_BOUNDS_CHECK_EN
        txn(1'b0, 1'b1, 9'd450, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, "wr450");
        txn(1'b1, 1'b0, 9'd450, 32'h0,        32'h0,        1'b1, "rd450");
        txn(1'b0, 1'b1, 9'd399, 32'hC0FFEE00, 32'h0,        1'b0, "wr399");
        txn(1'b1, 1'b0, 9'd399, 32'h0,        32'hC0FFEE00, 1'b0, "rd399");
`endif

        // Zero wait states: write one word, then hold read high.
        @(negedge clk);
        write0 = 1'b1; addr0 = 9'h003; wdata0 = 32'h13579BDF;
        c = 0; seen = 0;
        while (!seen && c < 10) begin
            @(negedge clk);
            c++;
            if (ready0) seen = 1;
        end
        check("zw_write_latency", 32'(c), 32'd2);
        write0 = 1'b0;
        @(negedge clk);
        read0 = 1'b1;
        c = 0; seen = 0;
        while (!seen && c < 10) begin
            @(negedge clk);
            c++;
            if (ready0) seen = 1;
        end
        check("zw_read_latency", 32'(c), 32'd2);
        check("zw_read_data", q0, 32'h13579BDF);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("zw_ready_%0d", i), 32'(ready0), (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i % 3 == 0) check($sformatf("zw_data_%0d", i), q0, 32'h13579BDF);
        end
        read0 = 1'b0;
        repeat (4) @(negedge clk);
        check("zw_idle_busy", 32'(busy0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
